// File: rtl/core_pkg.sv
// Shared types and constants for the physical-register allocation slice.
package core_pkg;

  localparam int unsigned PREGS          = 64;
  localparam int unsigned PREG_W         = $clog2(PREGS);
  localparam int unsigned REL_FIFO_DEPTH = 4;
  localparam int unsigned REL_PTR_W      = $clog2(REL_FIFO_DEPTH);
  localparam int unsigned REL_CNT_W      = $clog2(REL_FIFO_DEPTH + 1);

  typedef logic [PREG_W-1:0] preg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    EMPTY = 2'd2
  } alloc_state_e;

endpackage

// File: rtl/rel_fifo.sv
// Release buffer: small circular FIFO of pregs with three ordered write
// ports (port 0 lands first) and one read port.
module rel_fifo
  import core_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           wr_en_i,
  input  logic [PREG_W-1:0]    wr_data0_i,
  input  logic [PREG_W-1:0]    wr_data1_i,
  input  logic [PREG_W-1:0]    wr_data2_i,
  input  logic                 rd_en_i,
  output logic [PREG_W-1:0]    rd_data_o,
  output logic [REL_CNT_W-1:0] count_o
);

  preg_t                mem_q [REL_FIFO_DEPTH];
  logic [REL_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [REL_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [REL_CNT_W-1:0] count_q, count_d;
  logic [REL_PTR_W-1:0] wr_idx [3];
  logic [1:0]           n_push;
  logic                 pop;

  // Compact the enabled write ports onto consecutive slots after the tail.
  always_comb begin
    n_push = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      wr_idx[i] = wr_ptr_q + REL_PTR_W'(n_push);
      if (wr_en_i[i]) n_push = n_push + 2'd1;
    end
    pop      = rd_en_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q + REL_PTR_W'(n_push);
    rd_ptr_d = rd_ptr_q + REL_PTR_W'(pop);
    count_d  = count_q + REL_CNT_W'(n_push) - REL_CNT_W'(pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_en_i[0]) mem_q[wr_idx[0]] <= wr_data0_i;
    if (wr_en_i[1]) mem_q[wr_idx[1]] <= wr_data1_i;
    if (wr_en_i[2]) mem_q[wr_idx[2]] <= wr_data2_i;
  end

  // Head of queue and occupancy.
  always_comb begin
    rd_data_o = mem_q[rd_ptr_q];
    count_o   = count_q;
  end

endmodule

// File: rtl/preg_alloc_ctrl.sv
// Rename-side preg allocation controller: arbitrates two rename slots onto a
// single registered free-list alloc port, and buffers commit/flush releases
// into the free-list release port.
module preg_alloc_ctrl
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        rn_req,
  output logic [1:0]        rn_gnt,
  output logic [PREG_W-1:0] rn_preg0,
  output logic [PREG_W-1:0] rn_preg1,
  output logic              fl_alloc_en,
  input  logic [PREG_W-1:0] fl_alloc_phys,
  input  logic              fl_alloc_valid,
  output logic              fl_free_en,
  output logic [PREG_W-1:0] fl_free_phys,
  input  logic [1:0]        cm_free_en,
  input  logic [PREG_W-1:0] cm_free_phys0,
  input  logic [PREG_W-1:0] cm_free_phys1,
  output logic              cm_free_ready,
  input  logic              flush,
  output logic              fl_empty
);

  alloc_state_e         state_q, state_d;
  logic                 cur_slot_q, cur_slot_d;
  preg_t                preg0_q, preg1_q;
  logic [1:0]           gnt;
  logic                 alloc_req;
  logic                 reclaim;
  logic [REL_CNT_W-1:0] fifo_count;

  // Allocation FSM: next state, grant and alloc issue.
  always_comb begin
    state_d    = state_q;
    cur_slot_d = cur_slot_q;
    alloc_req  = 1'b0;
    gnt        = '0;
    reclaim    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush && (rn_req != 2'b00)) begin
          alloc_req  = 1'b1;
          cur_slot_d = ~rn_req[0];
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          reclaim = fl_alloc_valid;
          state_d = IDLE;
        end else if (fl_alloc_valid) begin
          gnt[cur_slot_q] = 1'b1;
          if (rn_req[~cur_slot_q]) begin
            alloc_req  = 1'b1;
            cur_slot_d = ~cur_slot_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = EMPTY;
        end
      end
      EMPTY: begin
        if (flush || fl_free_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; alloc issue is combinational from rn_req in IDLE, so it is
  // qualified with reset_n to stay quiet while reset is held.
  always_comb begin
    rn_gnt        = gnt;
    rn_preg0      = gnt[0] ? fl_alloc_phys : preg0_q;
    rn_preg1      = gnt[1] ? fl_alloc_phys : preg1_q;
    fl_alloc_en   = alloc_req && reset_n;
    fl_empty      = (state_q == EMPTY);
    fl_free_en    = (fifo_count != '0);
    cm_free_ready = (fifo_count <= REL_CNT_W'(1));
  end

  // State, current slot and held grant values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cur_slot_q <= 1'b0;
      preg0_q    <= '0;
      preg1_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_slot_q <= cur_slot_d;
      preg0_q    <= rn_preg0;
      preg1_q    <= rn_preg1;
    end
  end

  rel_fifo u_rel_fifo (
    .clk        (clk),
    .rst_n      (reset_n),
    .wr_en_i    ({cm_free_en[1], cm_free_en[0], reclaim}),
    .wr_data0_i (fl_alloc_phys),
    .wr_data1_i (cm_free_phys0),
    .wr_data2_i (cm_free_phys1),
    .rd_en_i    (fl_free_en),
    .rd_data_o  (fl_free_phys),
    .count_o    (fifo_count)
  );

endmodule

// File: doc/preg_alloc_ctrl.md
PREG_ALLOC_CTRL -- requirements
Module: preg_alloc_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; reset_n  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: rn_req  in  2  rename slot i requests one preg; held high until granted.
REQ-003 SHALL have ports: rn_gnt  out  2  one-cycle grant pulse per slot; rn_preg0, rn_preg1  out  6 each  granted preg, valid with the matching rn_gnt bit.
REQ-004 SHALL have ports: fl_alloc_en  out  1; fl_alloc_phys  in  6; fl_alloc_valid  in  1  free-list alloc port; result is registered and returns the cycle after fl_alloc_en.
REQ-005 SHALL have ports: fl_free_en  out  1; fl_free_phys  out  6  free-list release port, one release per cycle.
REQ-006 SHALL have ports: cm_free_en  in  2; cm_free_phys0, cm_free_phys1  in  6 each  commit-side releases; cm_free_ready  out  1  commit may assert cm_free_en only while this is high.
REQ-007 SHALL have ports: flush  in  1  pipeline flush; fl_empty  out  1  high while the controller is in the EMPTY state.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT, EMPTY.
REQ-009 IDLE: if any rn_req bit is ungranted, assert fl_alloc_en, latch cur_slot (slot 0 has priority over slot 1), and go to WAIT.
REQ-010 WAIT, fl_alloc_valid=1: pulse rn_gnt[cur_slot] and drive rn_preg<cur_slot> = fl_alloc_phys in the same cycle. If the other slot is still requesting, re-issue fl_alloc_en in that cycle (back-to-back) and stay in WAIT; otherwise go to IDLE.
REQ-011 WAIT, fl_alloc_valid=0: no grant; go to EMPTY.
REQ-012 EMPTY: assert fl_empty and issue no allocation. The cycle fl_free_en is high, go to IDLE; the retry issues on the following cycle.
REQ-013 Sustained throughput SHALL be one grant per cycle; latency from rn_req rise in IDLE to rn_gnt SHALL be 1 cycle.
REQ-014 A slot SHALL never be granted twice for one request. Slot 1 SHALL NOT be granted before slot 0 while both are requesting.
REQ-015 Release buffering: a 4-entry FIFO of 6-bit pregs.
REQ-016 Up to 3 FIFO pushes per cycle, in order: reclaim (REQ-019), cm_free_phys0, cm_free_phys1.
REQ-017 One FIFO pop per cycle: fl_free_en = FIFO non-empty; fl_free_phys = head. Push-to-release latency SHALL be 1 cycle minimum.
REQ-018 cm_free_ready SHALL be combinational: high when FIFO count <= 1. Overflow is therefore impossible.
REQ-019 flush in IDLE or EMPTY: go to IDLE, no grant that cycle. flush in WAIT: no grant; if fl_alloc_valid=1, push fl_alloc_phys into the FIFO as a reclaim; go to IDLE.
REQ-020 rn_req SHALL be ignored during the flush cycle. FIFO contents SHALL survive flush.
REQ-021 rn_gnt SHALL be 0 in every cycle without a valid grant. rn_preg0/1 SHALL hold their last value when not granting.

Reset
REQ-022 reset_n low SHALL asynchronously force: state IDLE, FIFO empty, rn_gnt=0, rn_preg0/1=0, fl_alloc_en=0, fl_free_en=0, fl_empty=0, cm_free_ready=1.
REQ-023 Reset mid-WAIT SHALL discard the outstanding result; the free list is reset by the same reset.

Structure
REQ-024 core_pkg SHALL hold: typedef preg_t (6 bits, from PREGS), constant REL_FIFO_DEPTH=4, and the FSM state enum.
REQ-025 The FIFO SHALL be a sub-module rel_fifo: 3 write ports with individual enables, 1 read port, count output.

Verification
REQ-026 Reset, then rn_req=2'b11, free list fresh: rn_gnt=01 with preg0=0 at cycle 1, rn_gnt=10 with preg1=1 at cycle 2, then IDLE.
REQ-027 Allocate all 64 pregs, then request slot 0: fl_alloc_valid=0 -> EMPTY, fl_empty=1. cm_free_en=01 with phys 17 -> fl_free_en/phys 17 one cycle later -> IDLE -> slot 0 granted preg 17.
REQ-028 flush in the WAIT cycle while fl_alloc_phys=5 is valid: no rn_gnt; preg 5 is released via fl_free_en within 2 cycles; a later allocation returns 5.
REQ-029 cm_free_en=11 for 2 consecutive cycles: cm_free_ready drops when count>1; fl_free_en releases all 4 pregs in push order, one per cycle; no loss.
REQ-030 Assert reset_n low during WAIT: all outputs reach reset values immediately; after release, first rn_req grants preg 0.
